// File: rtl/idli_uart_tx_m.sv
// UART transmitter: captures the low byte of a nibble-serial store word, queues it
// in a small FIFO and sends 8N1 frames. Define IDLI_UART_TX_PARITY_EN for 8E1 frames.
module idli_uart_tx_m #(
    parameter int DEPTH    = 4,
    parameter int BAUD_DIV = 16
) (
    input  logic       i_utx_gck,
    input  logic       i_utx_rst_n,
    input  logic [1:0] i_utx_ctr,
    input  logic       i_utx_wr_en,
    input  logic [3:0] i_utx_slice,
    output logic       o_utx_rdy,
    output logic       o_utx_busy,
    output logic       o_utx_tx
);

    localparam int PW = $clog2(DEPTH);
    localparam int BW = $clog2(BAUD_DIV);
    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [PW:0]   FULL      = (PW + 1)'(DEPTH);

`ifdef IDLI_UART_TX_PARITY_EN
    typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

    state_t          r_state;
    logic [BW-1:0]   r_baud;
    logic [2:0]      r_bit;
    logic [7:0]      r_shift;
    logic            r_tx;
`ifdef IDLI_UART_TX_PARITY_EN
    logic            r_parity;
`endif

    logic            r_pend;
    logic [3:0]      r_nib0;

    logic [7:0]      r_mem [DEPTH];
    logic [PW-1:0]   r_wptr;
    logic [PW-1:0]   r_rptr;
    logic [PW:0]     r_count;

    logic            w_push;
    logic            w_pop;
    logic            w_nonempty;
    logic            w_baud_end;
    logic [7:0]      w_head;

    assign w_nonempty = (r_count != '0);
    assign w_baud_end = (r_baud == BAUD_LAST);
    assign w_head     = r_mem[r_rptr];
    // The byte completes at the ctr==1 edge after an accepted ctr==0 request;
    // the space check was already made at ctr==0 and pops can only free room.
    assign w_push     = r_pend && (i_utx_ctr == 2'd1);
    assign w_pop      = w_nonempty &&
                        ((r_state == ST_IDLE) || ((r_state == ST_STOP) && w_baud_end));

    assign o_utx_rdy  = (r_count < FULL);
    assign o_utx_busy = (r_state != ST_IDLE) || w_nonempty;
    assign o_utx_tx   = r_tx;

    always_ff @(posedge i_utx_gck) begin
        if (!i_utx_rst_n) begin
            r_pend <= 1'b0;
            r_nib0 <= '0;
        end else begin
            r_pend <= (i_utx_ctr == 2'd0) && i_utx_wr_en && o_utx_rdy;
            if ((i_utx_ctr == 2'd0) && i_utx_wr_en) begin
                r_nib0 <= i_utx_slice;
            end
        end
    end

    always_ff @(posedge i_utx_gck) begin
        if (w_push) begin
            r_mem[r_wptr] <= {i_utx_slice, r_nib0};
        end
    end

    always_ff @(posedge i_utx_gck) begin
        if (!i_utx_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge i_utx_gck) begin
        if (!i_utx_rst_n) begin
            r_state  <= ST_IDLE;
            r_baud   <= '0;
            r_bit    <= '0;
            r_shift  <= '0;
            r_tx     <= 1'b1;
`ifdef IDLI_UART_TX_PARITY_EN
            r_parity <= 1'b0;
`endif
        end else begin
            r_baud <= w_baud_end ? '0 : r_baud + 1'b1;
            case (r_state)
                ST_IDLE: begin
                    r_baud <= '0;
                    r_tx   <= 1'b1;
                    if (w_pop) begin
                        r_state  <= ST_START;
                        r_shift  <= w_head;
                        r_tx     <= 1'b0;
`ifdef IDLI_UART_TX_PARITY_EN
                        r_parity <= ^w_head;
`endif
                    end
                end
                ST_START: begin
                    if (w_baud_end) begin
                        r_state <= ST_DATA;
                        r_bit   <= '0;
                        r_tx    <= r_shift[0];
                    end
                end
                ST_DATA: begin
                    if (w_baud_end) begin
                        if (r_bit == 3'd7) begin
`ifdef IDLI_UART_TX_PARITY_EN
                            r_state <= ST_PARITY;
                            r_tx    <= r_parity;
`else
                            r_state <= ST_STOP;
                            r_tx    <= 1'b1;
`endif
                        end else begin
                            r_bit   <= r_bit + 1'b1;
                            r_shift <= {1'b0, r_shift[7:1]};
                            r_tx    <= r_shift[1];
                        end
                    end
                end
`ifdef IDLI_UART_TX_PARITY_EN
                ST_PARITY: begin
                    if (w_baud_end) begin
                        r_state <= ST_STOP;
                        r_tx    <= 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    // A queued byte starts immediately so frames run back-to-back.
                    if (w_baud_end) begin
                        if (w_pop) begin
                            r_state  <= ST_START;
                            r_shift  <= w_head;
                            r_tx     <= 1'b0;
`ifdef IDLI_UART_TX_PARITY_EN
                            r_parity <= ^w_head;
`endif
                        end else begin
                            r_state <= ST_IDLE;
                            r_tx    <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_idli_uart_tx_m.sv
// Self-checking bench for idli_uart_tx_m: a frame-timeline model predicts the line,
// busy and ready for every cycle. Honours IDLI_UART_TX_PARITY_EN.
module tb_idli_uart_tx_m;

    localparam int B = 4;
    localparam int D = 4;
`ifdef IDLI_UART_TX_PARITY_EN
    localparam int FL = 11 * B;
`else
    localparam int FL = 10 * B;
`endif

    logic       clk;
    logic       rst_n;
    logic [1:0] ctr;
    logic       wr_en;
    logic [3:0] slice;
    logic       rdy;
    logic       busy;
    logic       tx;

    int          cyc;
    int          n_run  = 0;
    int          n_fail = 0;
    logic [15:0] cur_word = '0;

    // Accepted bytes: cycle they sit in the FIFO, cycle their start bit appears, value.
    int         m_entry [$];
    int         m_start [$];
    logic [7:0] m_data  [$];

    idli_uart_tx_m #(.DEPTH(D), .BAUD_DIV(B)) dut (
        .i_utx_gck   (clk),
        .i_utx_rst_n (rst_n),
        .i_utx_ctr   (ctr),
        .i_utx_wr_en (wr_en),
        .i_utx_slice (slice),
        .o_utx_rdy   (rdy),
        .o_utx_busy  (busy),
        .o_utx_tx    (tx)
    );

    initial begin
        clk = 1'b0;
        cyc = 0;
        ctr = 2'd0;
        forever begin
            #5 clk = 1'b1;
            #1 begin cyc = cyc + 1; ctr = ctr + 2'd1; end
            #4 clk = 1'b0;
        end
    end

    function automatic int occ(int t);
        int n = 0;
        foreach (m_entry[i]) if (m_entry[i] <= t && m_start[i] > t) n++;
        return n;
    endfunction

    function automatic logic in_frame(int t);
        logic v = 1'b0;
        foreach (m_start[i]) if (t >= m_start[i] && t < m_start[i] + FL) v = 1'b1;
        return v;
    endfunction

    function automatic logic exp_tx(int t);
        logic v = 1'b1;
        foreach (m_start[i]) begin
            if (t >= m_start[i] && t < m_start[i] + FL) begin
                int k = (t - m_start[i]) / B;
                if (k == 0) v = 1'b0;
                else if (k <= 8) v = m_data[i][k-1];
`ifdef IDLI_UART_TX_PARITY_EN
                else if (k == 9) v = ^m_data[i];
`endif
                else v = 1'b1;
            end
        end
        return v;
    endfunction

    function automatic logic exp_busy(int t);
        return in_frame(t) || (occ(t) > 0);
    endfunction

    function automatic logic exp_rdy(int t);
        return occ(t) < D;
    endfunction

    task automatic model_clear();
        m_entry.delete();
        m_start.delete();
        m_data.delete();
    endtask

    // Drives one cycle of inputs; stray wr_en on ctr!=0 cycles must be ignored.
    task automatic drive_cycle(input logic want, input logic [15:0] word, output logic accepted);
        int st;
        accepted = 1'b0;
        if (ctr == 2'd0) begin
            cur_word = word;
            wr_en    = want;
            slice    = word[3:0];
            if (want && rst_n && occ(cyc) < D) begin
                accepted = 1'b1;
                st = cyc + 3;
                if (m_start.size() > 0 && m_start[$] + FL > st) st = m_start[$] + FL;
                m_entry.push_back(cyc + 2);
                m_start.push_back(st);
                m_data.push_back(word[7:0]);
            end
        end else begin
            wr_en = 1'($urandom);
            slice = cur_word[int'(ctr)*4 +: 4];
        end
    endtask

    task automatic test_reset();
        logic acc;
        rst_n = 1'b0;
        wr_en = 1'b0;
        slice = 4'h0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            n_run++; if (tx !== 1'b1)   begin n_fail++; $display("[TB] FAIL reset_tx cyc=%0d got %b want 1", cyc, tx); end
            n_run++; if (rdy !== 1'b1)  begin n_fail++; $display("[TB] FAIL reset_rdy cyc=%0d got %b want 1", cyc, rdy); end
            n_run++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_busy cyc=%0d got %b want 0", cyc, busy); end
        end
        rst_n = 1'b1;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            n_run++; if (tx !== exp_tx(cyc))     begin n_fail++; $display("[TB] FAIL idle_tx cyc=%0d got %b want %b", cyc, tx, exp_tx(cyc)); end
            n_run++; if (busy !== exp_busy(cyc)) begin n_fail++; $display("[TB] FAIL idle_busy cyc=%0d got %b want %b", cyc, busy, exp_busy(cyc)); end
            n_run++; if (rdy !== exp_rdy(cyc))   begin n_fail++; $display("[TB] FAIL idle_rdy cyc=%0d got %b want %b", cyc, rdy, exp_rdy(cyc)); end
            drive_cycle(1'b0, 16'($urandom), acc);
        end
    endtask

    task automatic test_single_write(input logic [15:0] word);
        int   n0 = -1;
        int   low_at = -1;
        int   idle_at = -1;
        logic acc;
        for (int k = 0; k < 90; k++) begin
            @(negedge clk);
            n_run++; if (tx !== exp_tx(cyc))     begin n_fail++; $display("[TB] FAIL single_tx cyc=%0d got %b want %b", cyc, tx, exp_tx(cyc)); end
            n_run++; if (busy !== exp_busy(cyc)) begin n_fail++; $display("[TB] FAIL single_busy cyc=%0d got %b want %b", cyc, busy, exp_busy(cyc)); end
            n_run++; if (rdy !== exp_rdy(cyc))   begin n_fail++; $display("[TB] FAIL single_rdy cyc=%0d got %b want %b", cyc, rdy, exp_rdy(cyc)); end
            if (n0 >= 0 && low_at < 0 && tx === 1'b0) low_at = cyc;
            if (n0 >= 0 && idle_at < 0 && cyc > n0 + 2 && busy === 1'b0) idle_at = cyc;
            drive_cycle(n0 < 0, word, acc);
            if (acc) n0 = cyc;
        end
        n_run++; if (low_at != n0 + 3)       begin n_fail++; $display("[TB] FAIL single_start_latency got %0d want %0d", low_at, n0 + 3); end
        n_run++; if (idle_at != n0 + 3 + FL) begin n_fail++; $display("[TB] FAIL single_busy_drop got %0d want %0d", idle_at, n0 + 3 + FL); end
    endtask

    task automatic test_overflow();
        int          sidx = 0;
        logic        acc;
        logic        slot;
        logic [15:0] w;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            n_run++; if (tx !== exp_tx(cyc))     begin n_fail++; $display("[TB] FAIL ovf_tx cyc=%0d got %b want %b", cyc, tx, exp_tx(cyc)); end
            n_run++; if (busy !== exp_busy(cyc)) begin n_fail++; $display("[TB] FAIL ovf_busy cyc=%0d got %b want %b", cyc, busy, exp_busy(cyc)); end
            n_run++; if (rdy !== exp_rdy(cyc))   begin n_fail++; $display("[TB] FAIL ovf_rdy cyc=%0d got %b want %b", cyc, rdy, exp_rdy(cyc)); end
            slot = (ctr == 2'd0);
            if (slot && sidx == 5) begin
                n_run++; if (rdy !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_fifth_rdy got %b want 0", rdy); end
            end
            w = (sidx == 0) ? 16'($urandom) : {8'($urandom), 8'(sidx)};
            drive_cycle(sidx <= 5, w, acc);
            if (slot) sidx++;
        end
    endtask

    task automatic test_pointer_wrap();
        int          sidx = 0;
        logic        acc;
        logic        slot;
        logic [15:0] w;
        for (int k = 0; k < 460; k++) begin
            @(negedge clk);
            n_run++; if (tx !== exp_tx(cyc))     begin n_fail++; $display("[TB] FAIL wrap_tx cyc=%0d got %b want %b", cyc, tx, exp_tx(cyc)); end
            n_run++; if (busy !== exp_busy(cyc)) begin n_fail++; $display("[TB] FAIL wrap_busy cyc=%0d got %b want %b", cyc, busy, exp_busy(cyc)); end
            n_run++; if (rdy !== exp_rdy(cyc))   begin n_fail++; $display("[TB] FAIL wrap_rdy cyc=%0d got %b want %b", cyc, rdy, exp_rdy(cyc)); end
            slot = (ctr == 2'd0);
            w = {8'($urandom), 8'(8'h30 + sidx / 8)};
            drive_cycle((sidx % 8 == 0) && (sidx / 8 < 9), w, acc);
            if (slot) sidx++;
        end
    endtask

    task automatic test_random_back_to_back();
        int   sidx = 0;
        logic acc;
        logic slot;
        for (int k = 0; k < 520; k++) begin
            @(negedge clk);
            n_run++; if (tx !== exp_tx(cyc))     begin n_fail++; $display("[TB] FAIL rand_tx cyc=%0d got %b want %b", cyc, tx, exp_tx(cyc)); end
            n_run++; if (busy !== exp_busy(cyc)) begin n_fail++; $display("[TB] FAIL rand_busy cyc=%0d got %b want %b", cyc, busy, exp_busy(cyc)); end
            n_run++; if (rdy !== exp_rdy(cyc))   begin n_fail++; $display("[TB] FAIL rand_rdy cyc=%0d got %b want %b", cyc, rdy, exp_rdy(cyc)); end
            slot = (ctr == 2'd0);
            drive_cycle((sidx < 60) && ($urandom_range(0, 1) == 1), 16'($urandom), acc);
            if (slot) sidx++;
        end
    endtask

    task automatic test_reset_mid_frame();
        int          sidx = 0;
        int          n0 = -1;
        int          r_at = -1;
        logic        acc;
        logic        slot;
        logic [15:0] w;
        for (int k = 0; k < 160; k++) begin
            @(negedge clk);
            n_run++; if (tx !== exp_tx(cyc))     begin n_fail++; $display("[TB] FAIL midrst_tx cyc=%0d got %b want %b", cyc, tx, exp_tx(cyc)); end
            n_run++; if (busy !== exp_busy(cyc)) begin n_fail++; $display("[TB] FAIL midrst_busy cyc=%0d got %b want %b", cyc, busy, exp_busy(cyc)); end
            n_run++; if (rdy !== exp_rdy(cyc))   begin n_fail++; $display("[TB] FAIL midrst_rdy cyc=%0d got %b want %b", cyc, rdy, exp_rdy(cyc)); end
            if (r_at >= 0 && cyc == r_at + 1) begin
                n_run++; if (tx !== 1'b1)   begin n_fail++; $display("[TB] FAIL midrst_tx_after got %b want 1", tx); end
                n_run++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_busy_after got %b want 0", busy); end
            end
            rst_n = 1'b1;
            slot = (ctr == 2'd0);
            w = (sidx == 0) ? {8'($urandom), 8'hFF} : 16'($urandom);
            drive_cycle(sidx <= 2 && r_at < 0, w, acc);
            if (acc && n0 < 0) n0 = cyc;
            if (n0 >= 0 && r_at < 0 && cyc == n0 + 3 + 4 * B + 1) begin
                r_at  = cyc;
                rst_n = 1'b0;
                model_clear();
            end
            if (slot) sidx++;
        end
        n_run++; if (r_at < 0) begin n_fail++; $display("[TB] FAIL midrst_not_applied got %0d want >=0", r_at); end
    endtask

    initial begin
        test_reset();
        test_single_write(16'h12A5);
        test_single_write(16'hBC07);
        test_overflow();
        test_pointer_wrap();
        test_random_back_to_back();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
